pc_trace_reader: RTL and testbench

PC_TRACE_READER -- requirements
Module: pc_trace_reader

---
 rtl/pc_trace_reader_pkg.sv | 25 ++
 rtl/pc_trace_reader_trace_ram.sv | 25 ++
 rtl/pc_trace_reader.sv | 155 +++++++++++++++
 tb/tb_pc_trace_reader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_trace_reader_pkg.sv
// Shared trace-buffer definitions used by the PC, the trace reader and the display path.
package pc_trace_reader_pkg;

  localparam int TRACE_DEPTH = 8;
  localparam int TRACE_AW    = 16;

  localparam logic [7:0] DROPS_MAX = 8'd255;

  typedef enum logic {
    ST_LIVE   = 1'b0,
    ST_BROWSE = 1'b1
  } trace_state_e;

  // Saturating increment for the dropped-address counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == DROPS_MAX) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pc_trace_reader_trace_ram.sv
// Circular trace storage: synchronous write, asynchronous read.
module trace_ram #(
  parameter int DEPTH = 8,
  parameter int AW    = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [AW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [AW-1:0]            rdata
);

  logic [AW-1:0] mem_r [DEPTH];

  // Contents are left unreset; the occupancy count masks stale entries.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/pc_trace_reader.sv
// PC trace history with a LIVE/BROWSE cursor; shows the selected entry on the display.
module pc_trace_reader
  import pc_trace_reader_pkg::*;
#(
  parameter int  DEPTH = TRACE_DEPTH,
  parameter int  AW    = TRACE_AW,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          board_clk,
  input  logic          reset,
  input  logic [AW-1:0] addr_in,
  input  logic          addr_valid,
  input  logic          rd_prev,
  input  logic          rd_next,
  input  logic          freeze,
  output logic [AW-1:0] disp_addr,
  output logic [PW-1:0] disp_age,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          live,
  output logic [7:0]    drops
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  trace_state_e  state_r;
  trace_state_e  state_n_s;
  logic [PW-1:0] wp_r;
  logic [PW-1:0] wp_n_s;
  logic [PW-1:0] age_r;
  logic [PW-1:0] age_n_s;
  logic [PW-1:0] rd_idx_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_n_s;
  logic [AW-1:0] ram_rdata_s;
  logic [AW-1:0] disp_n_s;
  logic          wr_s;
  logic          drop_s;
  logic          prev_s;
  logic          next_s;

  trace_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_trace_ram (
    .clk   (board_clk),
    .we    (wr_s),
    .waddr (wp_r),
    .wdata (addr_in),
    .raddr (rd_idx_s),
    .rdata (ram_rdata_s)
  );

  // Next-state: write first, then navigation against the post-write buffer.
  always_comb begin
    wr_s   = addr_valid && !freeze && (state_r == ST_LIVE);
    drop_s = addr_valid && !wr_s;
    prev_s = rd_prev && !rd_next;
    next_s = rd_next && !rd_prev;

    if (wr_s) begin
      wp_n_s = wp_r + PW'(1);
    end else begin
      wp_n_s = wp_r;
    end

    if (wr_s && (count_r != DEPTH_C)) begin
      count_n_s = count_r + CW'(1);
    end else begin
      count_n_s = count_r;
    end

    state_n_s = state_r;
    age_n_s   = age_r;
    case (state_r)
      ST_LIVE: begin
        if (prev_s && (count_n_s >= CW'(2))) begin
          state_n_s = ST_BROWSE;
          age_n_s   = PW'(1);
        end else begin
          state_n_s = ST_LIVE;
          age_n_s   = '0;
        end
      end
      ST_BROWSE: begin
        if (prev_s) begin
          if ({1'b0, age_r} < (count_r - CW'(1))) begin
            age_n_s = age_r + PW'(1);
          end else begin
            age_n_s = age_r;
          end
        end else if (next_s) begin
          age_n_s = age_r - PW'(1);
          if (age_r == PW'(1)) begin
            state_n_s = ST_LIVE;
          end else begin
            state_n_s = ST_BROWSE;
          end
        end else begin
          age_n_s = age_r;
        end
      end
      default: begin
        state_n_s = ST_LIVE;
        age_n_s   = '0;
      end
    endcase

    // Newest entry sits just behind the write pointer; PW-bit math wraps modulo DEPTH.
    rd_idx_s = wp_n_s - PW'(1) - age_n_s;

    if (count_n_s == '0) begin
      disp_n_s = '0;
    end else if (wr_s && (rd_idx_s == wp_r)) begin
      disp_n_s = addr_in;
    end else begin
      disp_n_s = ram_rdata_s;
    end
  end

  // State, pointers, counters and registered display outputs.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_LIVE;
      wp_r      <= '0;
      count_r   <= '0;
      age_r     <= '0;
      disp_addr <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      live      <= 1'b1;
      drops     <= 8'd0;
    end else begin
      state_r   <= state_n_s;
      wp_r      <= wp_n_s;
      count_r   <= count_n_s;
      age_r     <= age_n_s;
      disp_addr <= disp_n_s;
      empty     <= (count_n_s == '0);
      full      <= (count_n_s == DEPTH_C);
      live      <= (state_n_s == ST_LIVE);
      if (drop_s) begin
        drops <= sat_inc8(drops);
      end else begin
        drops <= drops;
      end
    end
  end

  assign count    = count_r;
  assign disp_age = age_r;

endmodule

// File: tb/tb_pc_trace_reader.sv
// Scoreboard bench for pc_trace_reader against a newest-first history-list model.
module tb_pc_trace_reader;

  localparam int DEPTH = 8;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic          addr_valid = 1'b0;
  logic          rd_prev = 1'b0;
  logic          rd_next = 1'b0;
  logic          freeze = 1'b0;
  logic [AW-1:0] disp_addr;
  logic [2:0]    disp_age;
  logic [3:0]    count;
  logic          empty;
  logic          full;
  logic          live;
  logic [7:0]    drops;

  pc_trace_reader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .board_clk  (clk),
    .reset      (reset),
    .addr_in    (addr_in),
    .addr_valid (addr_valid),
    .rd_prev    (rd_prev),
    .rd_next    (rd_next),
    .freeze     (freeze),
    .disp_addr  (disp_addr),
    .disp_age   (disp_age),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .live       (live),
    .drops      (drops)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int age;
    int cnt;
    int empty;
    int full;
    int live;
    int drops;
  } exp_t;

  exp_t sb[$];

  // Reference model: history list, newest at index 0.
  logic [AW-1:0] hist[$];
  bit            browsing;
  int            m_age;
  int            m_drops;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    hist.delete();
    browsing = 1'b0;
    m_age    = 0;
    m_drops  = 0;
  endtask

  task automatic model_step(input bit av, input logic [AW-1:0] a, input bit p, input bit n, input bit f);
    exp_t e;
    bit pp, nn;
    if (av && !f && !browsing) begin
      hist.push_front(a);
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end else if (av) begin
      if (m_drops < 255) m_drops++;
    end
    pp = p && !n;
    nn = n && !p;
    if (!browsing) begin
      if (pp && hist.size() >= 2) begin
        browsing = 1'b1;
        m_age    = 1;
      end
    end else if (pp) begin
      if (m_age < hist.size() - 1) m_age++;
    end else if (nn) begin
      m_age--;
      if (m_age == 0) browsing = 1'b0;
    end
    e.addr  = (hist.size() == 0) ? 0 : int'(hist[m_age]);
    e.age   = m_age;
    e.cnt   = hist.size();
    e.empty = (hist.size() == 0);
    e.full  = (hist.size() == DEPTH);
    e.live  = !browsing;
    e.drops = m_drops;
    sb.push_back(e);
  endtask

  task automatic step(input bit av, input logic [AW-1:0] a, input bit p, input bit n, input bit f);
    @(negedge clk);
    addr_valid = av;
    addr_in    = a;
    rd_prev    = p;
    rd_next    = n;
    freeze     = f;
    @(posedge clk);
    model_step(av, a, p, n, f);
    #1;
    addr_valid = 1'b0;
    rd_prev    = 1'b0;
    rd_next    = 1'b0;
    freeze     = 1'b0;
  endtask

  // Asserted between edges; outputs must clear before the next edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    sb.delete();
    model_reset();
    #1;
    chk("rst_disp_addr", int'(disp_addr), 0);
    chk("rst_disp_age", int'(disp_age), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_live", int'(live), 1);
    chk("rst_drops", int'(drops), 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compares the outputs produced by each issued stimulus cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && sb.size() > 0) begin
      e = sb.pop_front();
      chk("disp_addr", int'(disp_addr), e.addr);
      chk("disp_age", int'(disp_age), e.age);
      chk("count", int'(count), e.cnt);
      chk("empty", int'(empty), e.empty);
      chk("full", int'(full), e.full);
      chk("live", int'(live), e.live);
      chk("drops", int'(drops), e.drops);
    end
  end

  initial begin
    model_reset();
    do_reset();
    for (int i = 1; i <= 3; i++) step(1'b1, AW'(i), 1'b0, 1'b0, 1'b0);

    do_reset();
    for (int i = 16'h10; i <= 16'h19; i++) step(1'b1, AW'(i), 1'b0, 1'b0, 1'b0);
    repeat (8) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, AW'(i), 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, AW'(16'hDE00 + i), 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    do_reset();
    step(1'b1, 16'h0042, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0043, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, AW'(i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0077, 1'b0, 1'b0, 1'b0);

    do_reset();
    step(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00AB, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'h00CD, 1'b1, 1'b1, 1'b1);

    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, AW'(16'h0500 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      step(($urandom_range(1) == 1), AW'($urandom), ($urandom_range(3) == 0),
           ($urandom_range(3) == 0), ($urandom_range(4) == 0));
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
